// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM state encoding
// and a ceiling-log2 helper used to size indices and counters.
package reg_share_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_shared_reg_word.sv
// One W-bit word of async-reset flops; loads d whenever en is high and
// otherwise holds its contents.
module shared_reg_word #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;

  // Load-enable mux in front of the storage flops.
  always_comb begin
    word_d = word_q;
    if (en) begin
      word_d = d;
    end
  end

  // Storage flops, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// A grant lasts one write cycle, or up to MAX_BURST cycles while the owner
// keeps req and lock asserted. Grants to different owners are always
// separated by one idle cycle, and a released owner drops to lowest priority.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int W         = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] owner_id,
  output logic [W-1:0]   q,
  output logic           q_vld,
  output logic           busy
);

  localparam int             BCW        = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(N - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_id_q, owner_id_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           q_vld_q, q_vld_d;

  logic [IDW-1:0] winner;
  logic           stay;
  logic           wr_en;
  logic [W-1:0]   wr_data;

  // Rotating-priority pick: first set request scanning ptr, ptr+1, ... mod N.
  always_comb begin
    logic           found;
    logic [IDW-1:0] cand;
    winner = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(ptr_q) + k >= N) begin
        cand = IDW'(int'(ptr_q) + k - N);
      end else begin
        cand = IDW'(int'(ptr_q) + k);
      end
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Owner keeps the register only while it still requests with lock and has burst budget left.
  always_comb begin
    stay = req[owner_id_q] & lock[owner_id_q] & (burst_cnt_q < BURST_LAST);
  end

  // Select the current owner's write data.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_id_q == IDW'(i)) begin
        wr_data = wdata[i*W +: W];
      end
    end
  end

  // Next-state logic for the IDLE/GRANT FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req) state_d = ST_GRANT;
      ST_GRANT: if (!stay) state_d = ST_IDLE;
    endcase
  end

  // Output and bookkeeping updates driven by the current state.
  always_comb begin
    ptr_d       = ptr_q;
    owner_id_d  = owner_id_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    q_vld_d     = (state_q == ST_GRANT);
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_id_d  = winner;
          gnt_d       = {{(N-1){1'b0}}, 1'b1} << winner;
          burst_cnt_d = '0;
        end else begin
          gnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (stay) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          ptr_d = (owner_id_q == LAST_ID) ? '0 : owner_id_q + 1'b1;
          gnt_d = '0;
        end
      end
    endcase
  end

  // State and control registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_id_q  <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
      q_vld_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_id_q  <= owner_id_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      q_vld_q     <= q_vld_d;
    end
  end

  assign wr_en = (state_q == ST_GRANT);

  shared_reg_word #(
    .W (W)
  ) u_word (
    .clk (clk),
    .rst (rst),
    .en  (wr_en),
    .d   (wr_data),
    .q   (q)
  );

  assign gnt      = gnt_q;
  assign owner_id = owner_id_q;
  assign q_vld    = q_vld_q;
  assign busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter (N=4, W=8, MAX_BURST=4): directed vector table,
// an asynchronous-reset sequence, and randomized traffic against a
// transaction-level ownership model.
module tb_reg_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]  gnt;
  logic [1:0]    owner_id;
  logic [W-1:0]  q;
  logic          q_vld;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_share_arbiter #(
    .N         (N),
    .W         (W),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .owner_id (owner_id),
    .q        (q),
    .q_vld    (q_vld),
    .busy     (busy)
  );

  typedef struct {
    bit          rst_first;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  e_gnt;
    logic [1:0]  e_oid;
    logic [7:0]  e_q;
    logic        e_qvld;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  // Ownership model state
  int         m_owner;
  int         m_writes;
  int         m_next;
  logic [7:0] m_q;
  logic       m_qvld;
  int         m_oid;

  function automatic vec_t mk(input bit rf, input logic [3:0] r, input logic [3:0] l,
                              input logic [31:0] wd, input logic [3:0] eg, input logic [1:0] eo,
                              input logic [7:0] eq, input logic ev, input logic eb);
    vec_t v;
    v.rst_first = rf; v.req = r; v.lock = l; v.wdata = wd;
    v.e_gnt = eg; v.e_oid = eo; v.e_q = eq; v.e_qvld = ev; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                         input logic [7:0] eq, input logic ev, input logic eb);
    chk({tag, ".gnt"},      32'(gnt),      32'(eg));
    chk({tag, ".owner_id"}, 32'(owner_id), 32'(eo));
    chk({tag, ".q"},        32'(q),        32'(eq));
    chk({tag, ".q_vld"},    32'(q_vld),    32'(ev));
    chk({tag, ".busy"},     32'(busy),     32'(eb));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; lock = '0; wdata = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_writes = 0; m_next = 0; m_q = '0; m_qvld = 1'b0; m_oid = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit found;
    if (m_owner < 0) begin
      m_qvld = 1'b0;
      if (req != 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_next + k) % N;
          if (!found && req[c]) begin
            m_owner = c;
            found   = 1'b1;
          end
        end
        m_oid    = m_owner;
        m_writes = 0;
      end
    end else begin
      m_q    = wdata[m_owner*W +: W];
      m_qvld = 1'b1;
      m_writes++;
      if (!(req[m_owner] && lock[m_owner] && m_writes < MB)) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req = '0; lock = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;

    // Single request
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h0000A500, 4'b0010, 2'd1, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000A500, 4'b0000, 2'd1, 8'hA5, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000A500, 4'b0000, 2'd1, 8'hA5, 1'b0, 1'b0));
    // Fairness with all requesting
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 2'd0, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b0000, 2'd0, 8'h11, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b0010, 2'd1, 8'h11, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b0000, 2'd1, 8'h22, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b0100, 2'd2, 8'h22, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b0000, 2'd2, 8'h33, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b1000, 2'd3, 8'h33, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b0000, 2'd3, 8'h44, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 2'd0, 8'h44, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h44332211, 4'b0000, 2'd0, 8'h11, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h44332211, 4'b0000, 2'd0, 8'h11, 1'b0, 1'b0));
    // Locked burst by requester 0, requester 1 waiting
    vecs.push_back(mk(1, 4'b0011, 4'b0001, 32'h00007710, 4'b0001, 2'd0, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 32'h00007710, 4'b0001, 2'd0, 8'h10, 1'b1, 1'b1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 32'h00007711, 4'b0001, 2'd0, 8'h11, 1'b1, 1'b1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 32'h00007712, 4'b0001, 2'd0, 8'h12, 1'b1, 1'b1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 32'h00007713, 4'b0000, 2'd0, 8'h13, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 32'h00007713, 4'b0010, 2'd1, 8'h13, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00007713, 4'b0000, 2'd1, 8'h77, 1'b1, 1'b0));
    // Pointer wrap 3 -> 0
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'hD0C0B0A0, 4'b0100, 2'd2, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'hD0C0B0A0, 4'b0000, 2'd2, 8'hC0, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 32'hD0C0B0A0, 4'b1000, 2'd3, 8'hC0, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 32'hD0C0B0A0, 4'b0000, 2'd3, 8'hD0, 1'b1, 1'b0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 32'hD0C0B0A0, 4'b0001, 2'd0, 8'hD0, 1'b0, 1'b1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'hD0C0B0A0, 4'b0000, 2'd0, 8'hA0, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) do_reset();
      req   = vecs[i].req;
      lock  = vecs[i].lock;
      wdata = vecs[i].wdata;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_oid, vecs[i].e_q,
              vecs[i].e_qvld, vecs[i].e_busy);
    end

    // Asynchronous reset in the middle of a locked burst
    do_reset();
    req = 4'b0001; lock = 4'b0001; wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    chk("arst_pre.gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("arst_pre.q", 32'(q), 32'h55);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all("arst_mid", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; req = 4'b0100; lock = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk_all("arst_after", 4'b0100, 2'd2, 8'h00, 1'b0, 1'b1);

    // Randomized traffic against the ownership model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
      lock  = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      wdata = $urandom;
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("rnd%0d", c),
              (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000,
              2'(m_oid), m_q, m_qvld, (m_owner >= 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
